// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter with round-robin tie-break, ownership locked for the whole cyc.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN (limit = TIMEOUT cycles).
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned AW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [31:0]   m0_dat_i,
    output logic [31:0]   m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [31:0]   m1_dat_i,
    output logic [31:0]   m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [3:0]    s_sel_o,
    output logic [AW-1:0] s_adr_o,
    output logic [31:0]   s_dat_o,
    input  logic [31:0]   s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,
    output logic [1:0]    grant_o
);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_arbiter2: TIMEOUT must lie in 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    // last_served: 0 = m0 served last, 1 = m1 served last
    logic   last_q, last_d;
    logic   tmo_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) state_d = last_q ? OWN0 : OWN1;
                else if (m0_cyc_i)        state_d = OWN0;
                else if (m1_cyc_i)        state_d = OWN1;
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

    logic [15:0] tmo_q, tmo_d;
    logic        own_stb;

    assign own_stb = (state_q == OWN0) ? m0_stb_i :
                     (state_q == OWN1) ? m1_stb_i : 1'b0;
    assign tmo_hit = (state_q != IDLE) && (tmo_q == TMO_LIMIT);

    // Counts consecutive stalled strobe cycles; any response, idle strobe or handover restarts it.
    always_comb begin
        if (state_d != state_q || tmo_hit || !own_stb || s_ack_i || s_err_i) tmo_d = 16'd0;
        else                                                                   tmo_d = tmo_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) tmo_q <= 16'd0;
        else       tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        grant_o  = 2'b00;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = 4'd0;
        s_adr_o  = '0;
        s_dat_o  = 32'd0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = 32'd0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = 32'd0;
        case (state_q)
            OWN0: begin
                grant_o  = 2'b01;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & ~tmo_hit;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | tmo_hit;
                m0_dat_o = s_dat_i;
            end
            OWN1: begin
                grant_o  = 2'b10;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & ~tmo_hit;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | tmo_hit;
                m1_dat_o = s_dat_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed scenarios, a per-cycle ownership model and literal spot checks.
// Define WB_ARB_TIMEOUT_EN to exercise the stall watchdog with TIMEOUT=4.
module tb_wb_arbiter2;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TB_TMO = 4;
`else
    localparam int TB_TMO = 255;
`endif
    localparam int AW = 32;

    logic          clk, reset;
    logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [3:0]    m0_sel, m1_sel;
    logic [AW-1:0] m0_adr, m1_adr;
    logic [31:0]   m0_wdat, m1_wdat, m0_rdat, m1_rdat;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic          s_cyc, s_stb, s_we, s_ack, s_err;
    logic [3:0]    s_sel;
    logic [AW-1:0] s_adr;
    logic [31:0]   s_wdat, s_rdat;
    logic [1:0]    grant;

    int n_checks = 0;
    int n_errors = 0;
    bit model_en = 0;

    wb_arbiter2 #(.TIMEOUT(TB_TMO), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel), .s_adr_o(s_adr),
        .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err), .grant_o(grant)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: who owns the bus, who was served last, stall run length ----------------
    int owner = -1;   // -1 idle, 0 = m0, 1 = m1
    int last  = 1;
    int stall = 0;

    always @(posedge clk) begin
        int nxt;
        bit ocyc, ostb, hit;
        if (reset) begin
            owner = -1;
            last  = 1;
            stall = 0;
        end else begin
            nxt  = owner;
            ocyc = (owner == 0) ? m0_cyc : (owner == 1) ? m1_cyc : 1'b0;
            ostb = (owner == 0) ? m0_stb : (owner == 1) ? m1_stb : 1'b0;
            if (owner < 0) begin
                if (m0_cyc && m1_cyc) nxt = (last == 1) ? 0 : 1;
                else if (m0_cyc)      nxt = 0;
                else if (m1_cyc)      nxt = 1;
            end else if (!ocyc) begin
                last = owner;
                nxt  = -1;
            end
`ifdef WB_ARB_TIMEOUT_EN
            hit = (owner >= 0) && (stall == TB_TMO);
            if (nxt == owner && owner >= 0 && ostb && !s_ack && !s_err && !hit) stall = stall + 1;
            else stall = 0;
`else
            hit = 1'b0;
            stall = 0;
`endif
            owner = nxt;
        end
    end

    // ---------------- compare every cycle, away from the active edge ----------------
    always @(negedge clk) begin
        bit            hit, own0, own1;
        logic [1:0]    eg;
        logic          ec, es, ew;
        logic [3:0]    esel;
        logic [AW-1:0] eadr;
        logic [31:0]   edat;
        if (model_en) begin
`ifdef WB_ARB_TIMEOUT_EN
            hit = (owner >= 0) && (stall == TB_TMO);
`else
            hit = 1'b0;
`endif
            own0 = (owner == 0);
            own1 = (owner == 1);
            eg   = {own1, own0};
            ec   = own0 ? m0_cyc : own1 ? m1_cyc : 1'b0;
            es   = (own0 ? m0_stb : own1 ? m1_stb : 1'b0) & ~hit;
            ew   = own0 ? m0_we : own1 ? m1_we : 1'b0;
            esel = own0 ? m0_sel : own1 ? m1_sel : 4'd0;
            eadr = own0 ? m0_adr : own1 ? m1_adr : '0;
            edat = own0 ? m0_wdat : own1 ? m1_wdat : 32'd0;
            check("grant", grant, eg);
            check("s_cyc", s_cyc, ec);
            check("s_stb", s_stb, es);
            check("s_we", s_we, ew);
            check("s_sel", s_sel, esel);
            check("s_adr", s_adr, eadr);
            check("s_dat", s_wdat, edat);
            check("m0_ack", m0_ack, own0 & s_ack);
            check("m1_ack", m1_ack, own1 & s_ack);
            check("m0_err", m0_err, own0 & (s_err | hit));
            check("m1_err", m1_err, own1 & (s_err | hit));
            check("m0_dat", m0_rdat, own0 ? s_rdat : 32'd0);
            check("m1_dat", m1_rdat, own1 ? s_rdat : 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic clear_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'h0; m0_adr = '0; m0_wdat = 32'd0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'h0; m1_adr = '0; m1_wdat = 32'd0;
        s_ack = 0; s_err = 0; s_rdat = 32'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    logic [1:0] gseq[$];
    int         n_err_pulses;

    initial begin
        clear_inputs();
        reset = 1'b1;
        step();
        model_en = 1;
        step();
        settle();
        check("reset_grant", grant, 2'b00);
        check("reset_s_cyc", s_cyc, 1'b0);
        check("reset_m0_ack", m0_ack, 1'b0);
        reset = 1'b0;

        // single read by m0, slave acks in the first owned cycle
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_sel = 4'hF; m0_adr = 32'h0000_1000;
        settle();
        check("read_grant_before", grant, 2'b00);
        step();
        s_ack = 1; s_rdat = 32'hDEAD_BEEF;
        settle();
        check("read_grant", grant, 2'b01);
        check("read_m0_dat", m0_rdat, 32'hDEAD_BEEF);
        check("read_m0_ack", m0_ack, 1'b1);
        check("read_m1_ack", m1_ack, 1'b0);
        check("read_s_adr", s_adr, 32'h0000_1000);
        step();
        clear_inputs();
        step();

        // simultaneous requests: round-robin order with turnaround cycles
        do_reset();
        for (int i = 0; i < 14; i++) begin
            m0_cyc = (i < 4) || (i >= 9); m0_stb = m0_cyc; m0_we = 1'b1;
            m0_sel = 4'h3; m0_adr = 32'h2000_0000 + 32'(i); m0_wdat = 32'h1100_0000 + 32'(i);
            m1_cyc = (i < 9); m1_stb = m1_cyc & i[0]; m1_we = 1'b0;
            m1_sel = 4'hC; m1_adr = 32'h3000_0000 + 32'(i); m1_wdat = 32'h2200_0000 + 32'(i);
            s_ack = i[0]; s_rdat = 32'hA500_0000 + 32'(i);
            settle();
            if (i >= 1 && (gseq.size() == 0 || gseq[$] != grant)) gseq.push_back(grant);
            step();
        end
        clear_inputs();
        check("rr_len", gseq.size(), 5);
        if (gseq.size() == 5) begin
            check("rr_g0", gseq[0], 2'b01);
            check("rr_g1", gseq[1], 2'b00);
            check("rr_g2", gseq[2], 2'b10);
            check("rr_g3", gseq[3], 2'b00);
            check("rr_g4", gseq[4], 2'b01);
        end
        step();

        // m0 locks the bus for 10 cycles while m1 keeps requesting
        do_reset();
        for (int i = 0; i < 14; i++) begin
            m0_cyc = (i < 10); m0_stb = m0_cyc;
            m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h4000_0000;
            s_ack = 1'b1; s_rdat = 32'h3400_0000 + 32'(i);
            settle();
            if (i == 1 || i == 10) begin
                check("lock_grant", grant, 2'b01);
                check("lock_m1_ack", m1_ack, 1'b0);
            end
            if (i == 11) check("lock_turnaround", grant, 2'b00);
            if (i == 12) check("lock_m1_granted", grant, 2'b10);
            step();
        end
        clear_inputs();
        step();

        // reset in the middle of an m1 cycle, then m0 wins the tie
        do_reset();
        m1_cyc = 1; m1_stb = 1;
        step();
        settle();
        check("rst_own1", grant, 2'b10);
        step();
        reset = 1'b1; m0_cyc = 1; m0_stb = 1;
        step();
        settle();
        check("rst_grant", grant, 2'b00);
        check("rst_s_cyc", s_cyc, 1'b0);
        step();
        reset = 1'b0;
        settle();
        check("rst_idle_after", grant, 2'b00);
        step();
        settle();
        check("rst_tie_m0", grant, 2'b01);
        step();
        clear_inputs();
        step();
        step();

        // spurious slave response while idle
        s_ack = 1; s_err = 1; s_rdat = 32'hFFFF_FFFF;
        settle();
        check("spur_m0_ack", m0_ack, 1'b0);
        check("spur_m1_ack", m1_ack, 1'b0);
        check("spur_m0_err", m0_err, 1'b0);
        check("spur_m1_dat", m1_rdat, 32'd0);
        step();
        clear_inputs();

        // slave never responds
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF; m0_adr = 32'h5000_0000;
        n_err_pulses = 0;
`ifdef WB_ARB_TIMEOUT_EN
        for (int i = 0; i < 13; i++) begin
            settle();
            if (m0_err) n_err_pulses++;
            if (i == 4) check("tmo_no_err_4", m0_err, 1'b0);
            if (i == 5) begin
                check("tmo_err_5", m0_err, 1'b1);
                check("tmo_stb_5", s_stb, 1'b0);
            end
            if (i == 6) begin
                check("tmo_err_6", m0_err, 1'b0);
                check("tmo_grant_6", grant, 2'b01);
            end
            step();
        end
        check("tmo_pulses", n_err_pulses, 2);
`else
        for (int i = 0; i < 105; i++) begin
            settle();
            if (m0_err) n_err_pulses++;
            step();
        end
        check("stall_no_err", n_err_pulses, 0);
        check("stall_grant", grant, 2'b01);
`endif
        clear_inputs();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
